// File: rtl/nios2_debug_jtag_host_master.sv
// -----------------------------------------------------------------------------
// nios2_debug_jtag_host_master
//
// Initiator side of the Nios II debug-slave virtual-JTAG link. A system-clock
// host hands over one (IR, DR) command. The block loads ir_in, then walks the
// virtual states UIR -> CDR -> SHIFT -> UDR -> RTI, generating tck and tdi.
// While it does so it collects the DR_WIDTH bits returned on tdo and hands
// them back as one response word.
//
// Handshakes: a transfer happens on a clk edge where valid and ready are both
// high. cmd_ready is high only in IDLE. rsp_valid is held until rsp_ready is
// seen, and neither valid depends combinationally on its own ready.
//
// Ports:
//   clk, reset_n             system clock, asynchronous active-low reset
//   cmd_valid/ready/ir/dr    command channel (dr shifted LSB first)
//   rsp_valid/ready/dr       response channel (bit 0 = first bit shifted)
//   busy                     a command is in progress
//   tck, tdi, tdo            generated JTAG clock and serial data
//   ir_in                    instruction presented to the slave
//   vs_uir/cdr/sdr/udr       virtual-state strobes, one full tck period each
//   jtag_state_rti           run-test-idle indication
//   fsm_state                current FSM state, for debug and checkers
//
// Optional feature: define NIOS2_JTAG_HOST_IR_CACHE_EN to skip the UIR period
// when the new IR equals the one loaded by the previous command.
// -----------------------------------------------------------------------------
module nios2_debug_jtag_host_master #(
   parameter int IR_WIDTH    = 2,
   parameter int DR_WIDTH    = 38,
   parameter int TCK_DIV     = 2,
   parameter int RTI_PERIODS = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [DR_WIDTH-1:0] cmd_dr,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DR_WIDTH-1:0] rsp_dr,
   output logic                busy,
   output logic                tck,
   output logic                tdi,
   input  logic                tdo,
   output logic [IR_WIDTH-1:0] ir_in,
   output logic                vs_uir,
   output logic                vs_cdr,
   output logic                vs_sdr,
   output logic                vs_udr,
   output logic                jtag_state_rti,
   output logic [2:0]          fsm_state
);

   localparam int              BW       = $clog2(DR_WIDTH + 1);
   localparam logic [7:0]      HP_MAX   = 8'(TCK_DIV - 1);
   localparam logic [BW-1:0]   BIT_LOAD = BW'(DR_WIDTH - 1);
   localparam logic [3:0]      RTI_LOAD = 4'(RTI_PERIODS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_UIR   = 3'd1,
      S_CDR   = 3'd2,
      S_SHIFT = 3'd3,
      S_UDR   = 3'd4,
      S_RTI   = 3'd5,
      S_RESP  = 3'd6
   } state_t;

   state_t              state, state_nxt;
   logic                arm;        // one-cycle gap between accept and first period
   logic [7:0]          hp_cnt;     // clk cycles within the current tck half-period
   logic                tck_q;
   logic [DR_WIDTH-1:0] sr;
   logic [DR_WIDTH-1:0] cap;
   logic [DR_WIDTH-1:0] rsp_q;
   logic [BW-1:0]       bit_cnt;
   logic [3:0]          rti_cnt;
   logic [IR_WIDTH-1:0] ir_q;
   logic                timed, half_end, tck_rise, period_end, accept, hit;

   assign timed      = (state == S_UIR) || (state == S_CDR) || (state == S_SHIFT) ||
                       (state == S_UDR) || (state == S_RTI);
   assign half_end   = timed && !arm && (hp_cnt == HP_MAX);
   assign tck_rise   = half_end && !tck_q;
   assign period_end = half_end && tck_q;
   assign accept     = cmd_valid && (state == S_IDLE);

`ifdef NIOS2_JTAG_HOST_IR_CACHE_EN
   logic                cache_vld;
   logic [IR_WIDTH-1:0] cache_ir;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cache_vld <= 1'b0;
         cache_ir  <= '0;
      end else if (accept) begin
         cache_vld <= 1'b1;
         cache_ir  <= cmd_ir;
      end
   end

   assign hit = cache_vld && (cmd_ir == cache_ir);
`else
   assign hit = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept)     state_nxt = hit ? S_CDR : S_UIR;
         S_UIR:   if (period_end) state_nxt = S_CDR;
         S_CDR:   if (period_end) state_nxt = S_SHIFT;
         S_SHIFT: if (period_end && (bit_cnt == '0)) state_nxt = S_UDR;
         S_UDR:   if (period_end) state_nxt = S_RTI;
         S_RTI:   if (period_end && (rti_cnt == 4'd0)) state_nxt = S_RESP;
         S_RESP:  if (rsp_ready)  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Timing, shift and capture datapath
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         arm     <= 1'b0;
         hp_cnt  <= 8'd0;
         tck_q   <= 1'b0;
         sr      <= '0;
         cap     <= '0;
         rsp_q   <= '0;
         bit_cnt <= '0;
         rti_cnt <= 4'd0;
         ir_q    <= '0;
      end else begin
         arm <= accept;

         if (!timed || arm || half_end) hp_cnt <= 8'd0;
         else                           hp_cnt <= hp_cnt + 8'd1;

         // tck returns to 0 on the last period end, so it is low in RESP/IDLE
         if (!timed)        tck_q <= 1'b0;
         else if (half_end) tck_q <= ~tck_q;

         if (accept) begin
            sr   <= cmd_dr;
            ir_q <= cmd_ir;
         end else if ((state == S_SHIFT) && period_end) begin
            sr <= sr >> 1;
         end

         // tdo enters at the top so the first bit ends up in bit 0
         if ((state == S_SHIFT) && tck_rise) cap <= {tdo, cap[DR_WIDTH-1:1]};

         if ((state == S_CDR) && period_end)                          bit_cnt <= BIT_LOAD;
         else if ((state == S_SHIFT) && period_end && (bit_cnt != '0)) bit_cnt <= bit_cnt - 1'b1;

         if ((state == S_UDR) && period_end)      rti_cnt <= RTI_LOAD;
         else if ((state == S_RTI) && period_end) rti_cnt <= rti_cnt - 4'd1;

         if ((state == S_RTI) && period_end && (rti_cnt == 4'd0)) rsp_q <= cap;
      end
   end

   // Outputs
   always_comb begin
      cmd_ready      = (state == S_IDLE);
      busy           = (state != S_IDLE);
      rsp_valid      = (state == S_RESP);
      rsp_dr         = rsp_q;
      tck            = tck_q;
      ir_in          = ir_q;
      vs_uir         = (state == S_UIR);
      vs_cdr         = (state == S_CDR);
      vs_sdr         = (state == S_SHIFT);
      vs_udr         = (state == S_UDR);
      jtag_state_rti = (state == S_RTI);
      tdi            = (state == S_SHIFT) ? sr[0] : 1'b0;
      fsm_state      = state;
   end

endmodule

// File: tb/tb_nios2_debug_jtag_host_master.sv
// -----------------------------------------------------------------------------
// Bench for nios2_debug_jtag_host_master (default parameters). Commands come
// from a table of records; the tdo source is either a loopback of tdi or a
// slave model shifting out a preloaded word on tck. Multi-cycle corner cases
// (held response, back-to-back acceptance, reset mid-shift) are written out
// by hand after the table.
// -----------------------------------------------------------------------------
module tb_nios2_debug_jtag_host_master;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_ir;
   logic [37:0] cmd_dr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [37:0] rsp_dr;
   logic        busy, tck, tdi, tdo;
   logic [1:0]  ir_in;
   logic        vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti;
   logic [2:0]  fsm_state;

   int n_checks = 0;
   int n_fail   = 0;

   // tdo source
   logic        slave_mode = 1'b0;
   logic [37:0] slave_word = '0;
   logic [37:0] slave_sr;
   logic        slave_load = 1'b0;
   logic        cnt_clr    = 1'b0;
   int          n_uir, n_cdr, n_sdr, n_udr, n_rti;

`ifdef NIOS2_JTAG_HOST_IR_CACHE_EN
   bit          cache_vld_m = 1'b0;
   logic [1:0]  last_ir_m   = 2'b00;
`endif

   typedef struct {
      logic [1:0]  ir;
      logic [37:0] dr;
      logic        slave;
      logic [37:0] tdo_word;
      logic [37:0] exp_rsp;
   } vec_t;

   vec_t vecs[6];

   nios2_debug_jtag_host_master dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_ir         (cmd_ir),
      .cmd_dr         (cmd_dr),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_dr         (rsp_dr),
      .busy           (busy),
      .tck            (tck),
      .tdi            (tdi),
      .tdo            (tdo),
      .ir_in          (ir_in),
      .vs_uir         (vs_uir),
      .vs_cdr         (vs_cdr),
      .vs_sdr         (vs_sdr),
      .vs_udr         (vs_udr),
      .jtag_state_rti (jtag_state_rti),
      .fsm_state      (fsm_state)
   );

   // Clock
   always #5 clk = ~clk;

   assign tdo = slave_mode ? slave_sr[0] : tdi;

   // Slave model: presents the next bit after each sampling tck edge in SHIFT
   always @(posedge tck or posedge slave_load) begin
      if (slave_load)  slave_sr <= slave_word;
      else if (vs_sdr) slave_sr <= slave_sr >> 1;
   end

   // Count tck periods spent under each strobe
   always @(posedge tck or posedge cnt_clr) begin
      if (cnt_clr) begin
         n_uir <= 0; n_cdr <= 0; n_sdr <= 0; n_udr <= 0; n_rti <= 0;
      end else begin
         if (vs_uir)         n_uir <= n_uir + 1;
         if (vs_cdr)         n_cdr <= n_cdr + 1;
         if (vs_sdr)         n_sdr <= n_sdr + 1;
         if (vs_udr)         n_udr <= n_udr + 1;
         if (jtag_state_rti) n_rti <= n_rti + 1;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Expected number of UIR periods for a command with this IR
   task automatic model_uir(input logic [1:0] ir, output int e);
      e = 1;
`ifdef NIOS2_JTAG_HOST_IR_CACHE_EN
      if (cache_vld_m && (ir == last_ir_m)) e = 0;
      cache_vld_m = 1'b1;
      last_ir_m   = ir;
`endif
   endtask

   task automatic prep_tdo(input logic mode, input logic [37:0] word);
      slave_mode = mode;
      slave_word = word;
      slave_load = 1'b1;
      cnt_clr    = 1'b1;
      #1;
      slave_load = 1'b0;
      cnt_clr    = 1'b0;
   endtask

   // Called at a negedge right after the accept edge; lat = edges to rsp_valid
   task automatic wait_rsp(input logic [1:0] ir, output int lat, output int bad);
      lat = 0;
      bad = 0;
      if (ir_in !== ir) bad++;
      for (int n = 1; n <= 400; n++) begin
         @(negedge clk);
         if (ir_in !== ir) bad++;
         if (rsp_valid === 1'b1) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic handshake(input logic [37:0] exp);
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check("hs_cmd_ready", cmd_ready, 1);
      check("hs_rsp_valid_low", rsp_valid, 0);
      check("rsp_dr_hold", rsp_dr, exp);
   endtask

   task automatic run_vec(input vec_t v, input bit do_hs);
      int e_uir, lat, bad;
      check("pre_cmd_ready", cmd_ready, 1);
      model_uir(v.ir, e_uir);
      prep_tdo(v.slave, v.tdo_word);
      cmd_ir    = v.ir;
      cmd_dr    = v.dr;
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("accepted_busy", busy, 1);
      wait_rsp(v.ir, lat, bad);
      check("latency", 64'(lat), (e_uir == 1) ? 64'd173 : 64'd169);
      check("rsp_dr", rsp_dr, v.exp_rsp);
      check("uir_periods", 64'(n_uir), 64'(e_uir));
      check("cdr_periods", 64'(n_cdr), 1);
      check("sdr_periods", 64'(n_sdr), 38);
      check("udr_periods", 64'(n_udr), 1);
      check("rti_periods", 64'(n_rti), 2);
      check("ir_in_stable", 64'(bad), 0);
      if (do_hs) handshake(v.exp_rsp);
   endtask

   initial begin
      int   e_uir, lat, bad, pulses;
      vec_t v;

      vecs[0] = '{ir: 2'b01, dr: 38'h2A_5A5A_5A5A, slave: 1'b0, tdo_word: 38'h0,            exp_rsp: 38'h2A_5A5A_5A5A};
      vecs[1] = '{ir: 2'b10, dr: 38'h00_0000_0000, slave: 1'b1, tdo_word: 38'h3F_0000_0001, exp_rsp: 38'h3F_0000_0001};
      vecs[2] = '{ir: 2'b10, dr: 38'h15_5555_5555, slave: 1'b1, tdo_word: 38'h00_DEAD_BEEF, exp_rsp: 38'h00_DEAD_BEEF};
      vecs[3] = '{ir: 2'b00, dr: 38'h3F_FFFF_FFFF, slave: 1'b0, tdo_word: 38'h0,            exp_rsp: 38'h3F_FFFF_FFFF};
      vecs[4] = '{ir: 2'b00, dr: 38'h00_0000_0001, slave: 1'b0, tdo_word: 38'h0,            exp_rsp: 38'h00_0000_0001};
      vecs[5] = '{ir: 2'b11, dr: 38'h20_0000_0000, slave: 1'b0, tdo_word: 38'h0,            exp_rsp: 38'h20_0000_0000};

      // Reset held with a command pending
      reset_n   = 1'b0;
      cmd_valid = 1'b1;
      cmd_ir    = 2'b11;
      cmd_dr    = '1;
      rsp_ready = 1'b0;
      prep_tdo(1'b0, 38'h0);
      repeat (5) @(negedge clk);
      check("rst_tck", tck, 0);
      check("rst_strobes", {vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti}, 0);
      check("rst_tdi", tdi, 0);
      check("rst_ir_in", ir_in, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_dr", rsp_dr, 0);
      check("rst_busy", busy, 0);
      check("rst_state", fsm_state, 0);
      cmd_valid = 1'b0;
      reset_n   = 1'b1;
      @(negedge clk);

      // Table of commands
      for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b1);

      // Held response, second command pending throughout
      v = '{ir: 2'b01, dr: 38'h0A_BCDE_F012, slave: 1'b0, tdo_word: 38'h0, exp_rsp: 38'h0A_BCDE_F012};
      run_vec(v, 1'b0);
      cmd_ir    = 2'b10;
      cmd_dr    = 38'h11_2233_4455;
      cmd_valid = 1'b1;
      bad       = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_dr !== 38'h0A_BCDE_F012 || cmd_ready !== 1'b0) bad++;
      end
      check("rsp_held", 64'(bad), 0);
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check("b2b_not_same_edge", cmd_ready, 1);
      check("b2b_rsp_done", rsp_valid, 0);
      model_uir(2'b10, e_uir);
      prep_tdo(1'b0, 38'h0);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("b2b_accept_next", cmd_ready, 0);
      wait_rsp(2'b10, lat, bad);
      check("b2b_latency", 64'(lat), (e_uir == 1) ? 64'd173 : 64'd169);
      check("b2b_rsp_dr", rsp_dr, 38'h11_2233_4455);
      check("b2b_ir_stable", 64'(bad), 0);
      handshake(38'h11_2233_4455);

      // Reset in the middle of SHIFT
      model_uir(2'b01, e_uir);
      prep_tdo(1'b0, 38'h0);
      cmd_ir    = 2'b01;
      cmd_dr    = 38'h3C_0F0F_0F0F;
      cmd_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int n = 0; n < 400 && n_sdr < 17; n++) @(negedge clk);
      check("reached_bit17", 64'(n_sdr), 17);
      #2;
      reset_n = 1'b0;
`ifdef NIOS2_JTAG_HOST_IR_CACHE_EN
      cache_vld_m = 1'b0;
`endif
      #1;
      check("mid_rst_sdr", vs_sdr, 0);
      check("mid_rst_tck", tck, 0);
      check("mid_rst_busy", busy, 0);
      @(negedge clk);
      reset_n = 1'b1;
      pulses  = 0;
      for (int n = 0; n < 250; n++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) pulses++;
      end
      check("no_partial_rsp", 64'(pulses), 0);
      check("post_rst_ready", cmd_ready, 1);

      // Same IR as before the reset: the reset must have forgotten it
      v = '{ir: 2'b01, dr: 38'h05_A5A5_0001, slave: 1'b1, tdo_word: 38'h2F_1234_5678, exp_rsp: 38'h2F_1234_5678};
      run_vec(v, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/nios2_debug_jtag_host_master.md
Name: nios2_debug_jtag_host_master

Overview:
- Initiator side of the Nios II debug-slave virtual-JTAG link.
- Takes a (2-bit IR, 38-bit DR) command from a system-clock host, bit-bangs tck/tdi, and sequences the virtual-state strobes (uir/cdr/sdr/udr/rti) the debug slave responds to.
- Returns the 38-bit word shifted out on tdo.
- Used in simulation benches and on-chip self-test in place of the hard sld_virtual_jtag_basic hub.

Parameters:
- IR_WIDTH, 2, width of instruction register (ir_in).
- DR_WIDTH, 38, data-register shift length per command.
- TCK_DIV, 2, clk cycles per tck half-period; legal range 1..255.
- RTI_PERIODS, 2, tck periods spent in run-test-idle after UDR; legal range 1..15.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_ir  in  IR_WIDTH  instruction to load.
- cmd_dr  in  DR_WIDTH  data to shift in, LSB first.
- rsp_valid  out  1  capture word available.
- rsp_ready  in  1  host consumes capture word.
- rsp_dr  out  DR_WIDTH  word captured from tdo, bit 0 = first bit shifted.
- busy  out  1  command in progress (state != IDLE).
- tck  out  1  generated JTAG clock.
- tdi  out  1  serial data to slave.
- tdo  in  1  serial data from slave.
- ir_in  out  IR_WIDTH  instruction presented to slave.
- vs_uir, vs_cdr, vs_sdr, vs_udr  out  1 each  virtual-state strobes.
- jtag_state_rti  out  1  run-test-idle indication.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values:
  - tck=0, tdi=0, ir_in=0, all strobes and jtag_state_rti = 0.
  - cmd_ready=1, rsp_valid=0, rsp_dr=0, busy=0, state=IDLE.
- tck period:
  - One "period" = 2*TCK_DIV clk cycles.
  - tck is low for the first TCK_DIV cycles of each period and high for the second TCK_DIV.
  - tck is held at 0 in IDLE and RESP.
- Strobe and tdi timing: each is asserted for the whole of its period, so the slave samples it on the tck rising edge.
- Accept: cmd_valid & cmd_ready at clk edge 0.
  - Latch cmd_ir and cmd_dr into the shift register.
  - cmd_ready drops and the FSM enters UIR on the same edge; its first period starts at cycle 1.
- FSM, one state per listed period count:
  - IDLE: waits for accept.
  - UIR (1 period): ir_in <= latched IR at state entry; vs_uir=1.
  - CDR (1 period): vs_cdr=1.
  - SHIFT (DR_WIDTH periods): vs_sdr=1; tdi = sr[0].
    - On the clk cycle where tck rises: sample tdo into cap[DR_WIDTH-1], shifting cap right.
    - At the period end: shift sr right.
  - UDR (1 period): vs_udr=1; tdi=0.
  - RTI (RTI_PERIODS periods): jtag_state_rti=1.
  - RESP: rsp_dr=cap, rsp_valid=1, held until rsp_ready; then go to IDLE, cmd_ready=1.
- Latency: rsp_valid rises at cycle 1 + (DR_WIDTH+3+RTI_PERIODS)*2*TCK_DIV. Defaults give cycle 173.
- Counters:
  - Half-period counter: 8 bits.
  - Bit counter: ceil(log2(DR_WIDTH+1)) bits, counting DR_WIDTH-1 down to 0.
  - RTI counter: 4 bits.
- Boundary conditions:
  - cmd_valid while busy: ignored; input is not sampled.
  - rsp_ready and cmd_valid both high in RESP: response completes; the new command is not accepted until the following cycle in IDLE.
  - rsp_dr holds its value after the handshake until the next RESP.
  - ir_in holds its last value in IDLE; the slave relies on ir_in being stable between commands.
  - reset_n low mid-command: immediate return to reset values; no strobe is left asserted and no partial response is issued.
  - tdo is sampled only in SHIFT.

Optional Feature:
- Macro: NIOS2_JTAG_HOST_IR_CACHE_EN.
- Defined:
  - A valid flag and the last-loaded IR are kept (both cleared by reset).
  - If the latched cmd_ir equals the cached IR and the flag is valid, UIR is skipped: the FSM goes straight to CDR, and latency drops by one period (defaults: cycle 169).
- Undefined: UIR runs on every command; no cache logic is generated.

Test Plan:
1. Reset:
   - Stimulus: hold reset_n=0, toggle clk, drive cmd_valid=1.
   - Required: tck=0, all strobes 0, cmd_ready=1, rsp_valid=0, rsp_dr=0; no state change.
2. Loopback (tdo tied to tdi), defaults:
   - Stimulus: cmd_ir=2'b01, cmd_dr=38'h2A_5A5A_5A5A.
   - Required: exactly 1 uir, 1 cdr, 38 sdr, 1 udr and 2 rti tck periods; rsp_valid at cycle 173; rsp_dr=38'h2A_5A5A_5A5A.
3. Slave model drives tdo from a preloaded 38'h3F_0000_0001, LSB first:
   - Required: rsp_dr=38'h3F_0000_0001; ir_in=2'b10 stable from UIR through RESP.
4. Back-to-back with rsp_ready held 0 for 10 cycles:
   - Required: rsp_valid stays high and rsp_dr stays stable.
   - Stimulus: second cmd_valid asserted throughout.
   - Required: it is accepted only on the cycle after the rsp handshake.
5. Reset mid-SHIFT:
   - Stimulus: drop reset_n at bit 17.
   - Required: vs_sdr=0 and tck=0 immediately; after release, cmd_ready=1 and no rsp_valid pulse.
6. With NIOS2_JTAG_HOST_IR_CACHE_EN:
   - Stimulus: two commands with cmd_ir=2'b00.
   - Required: the first shows vs_uir and responds at cycle 173; the second has no vs_uir and responds 169 cycles after its accept.
   - Stimulus: a third command with cmd_ir=2'b11.
   - Required: vs_uir is asserted again.
